// File: rtl/swan_kat_sequencer_if.sv
// Handshake bundle between the SWAN KAT sequencer and its environment:
// vector table lookup, encrypt/decrypt core control and status.
interface swan_kat_sequencer_if #(
  parameter int BLOCK_SIZE = 64,
  parameter int KEY_SIZE   = 128
);
  logic                  run;
  logic [1:0]            mode;
  logic [7:0]            vec_addr;
  logic [KEY_SIZE-1:0]   vec_key;
  logic [BLOCK_SIZE-1:0] vec_pt;
  logic [BLOCK_SIZE-1:0] vec_ct;
  logic                  enc_start;
  logic                  dec_start;
  logic [KEY_SIZE-1:0]   core_key;
  logic [BLOCK_SIZE-1:0] core_inp;
  logic [BLOCK_SIZE-1:0] enc_out;
  logic                  enc_ready;
  logic [BLOCK_SIZE-1:0] dec_out;
  logic                  dec_ready;
  logic                  busy;
  logic                  done;
  logic                  pass;
  logic [7:0]            fail_cnt;
  logic [7:0]            first_fail;
  logic                  timeout;

  modport master (
    input  run, mode,
    input  vec_key, vec_pt, vec_ct,
    input  enc_out, enc_ready,
    input  dec_out, dec_ready,
    output vec_addr,
    output enc_start, dec_start,
    output core_key, core_inp,
    output busy, done, pass,
    output fail_cnt, first_fail, timeout
  );

  modport slave (
    output run, mode,
    output vec_key, vec_pt, vec_ct,
    output enc_out, enc_ready,
    output dec_out, dec_ready,
    input  vec_addr,
    input  enc_start, dec_start,
    input  core_key, core_inp,
    input  busy, done, pass,
    input  fail_cnt, first_fail, timeout
  );
endinterface

// File: rtl/swan_kat_sequencer.sv
// Known-answer-test sequencer: walks a vector table through external
// SWAN encrypt/decrypt cores and reports pass/fail status.
module swan_kat_sequencer #(
  parameter int BLOCK_SIZE = 64,
  parameter int KEY_SIZE   = 128,
  parameter int NUM_VEC    = 3,
  parameter int TIMEOUT    = 1023
) (
  input  logic clk,
  input  logic rst,
  swan_kat_sequencer_if.master bus
);

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_E_GO,
    S_E_WAIT,
    S_D_GO,
    S_D_WAIT,
    S_NEXT,
    S_FIN
  } state_e;

  state_e                state_q, state_d;
  logic                  run_q, run_d;
  logic [1:0]            mode_q, mode_d;
  logic [7:0]            vec_addr_q, vec_addr_d;
  logic [KEY_SIZE-1:0]   core_key_q, core_key_d;
  logic [BLOCK_SIZE-1:0] core_inp_q, core_inp_d;
  logic                  enc_start_q, enc_start_d;
  logic                  dec_start_q, dec_start_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  pass_q, pass_d;
  logic [7:0]            fail_cnt_q, fail_cnt_d;
  logic [7:0]            first_fail_q, first_fail_d;
  logic                  timeout_q, timeout_d;
  logic                  fail_hit;
  logic [CW-1:0]         cnt_inc;

  assign cnt_inc = cnt_q + CW'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      run_q        <= 1'b0;
      mode_q       <= 2'd0;
      vec_addr_q   <= 8'd0;
      core_key_q   <= '0;
      core_inp_q   <= '0;
      enc_start_q  <= 1'b0;
      dec_start_q  <= 1'b0;
      cnt_q        <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      fail_cnt_q   <= 8'd0;
      first_fail_q <= 8'hFF;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      run_q        <= run_d;
      mode_q       <= mode_d;
      vec_addr_q   <= vec_addr_d;
      core_key_q   <= core_key_d;
      core_inp_q   <= core_inp_d;
      enc_start_q  <= enc_start_d;
      dec_start_q  <= dec_start_d;
      cnt_q        <= cnt_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      fail_cnt_q   <= fail_cnt_d;
      first_fail_q <= first_fail_d;
      timeout_q    <= timeout_d;
    end
  end

  // Core inputs and start pulses are registered on entry to the GO
  // states so that start and its operands are presented together.
  always_comb begin
    state_d      = state_q;
    run_d        = bus.run;
    mode_d       = mode_q;
    vec_addr_d   = vec_addr_q;
    core_key_d   = core_key_q;
    core_inp_d   = core_inp_q;
    enc_start_d  = 1'b0;
    dec_start_d  = 1'b0;
    cnt_d        = cnt_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    pass_d       = pass_q;
    fail_cnt_d   = fail_cnt_q;
    first_fail_d = first_fail_q;
    timeout_d    = timeout_q;
    fail_hit     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.run && !run_q) begin
          mode_d       = bus.mode;
          fail_cnt_d   = 8'd0;
          pass_d       = 1'b0;
          timeout_d    = 1'b0;
          first_fail_d = 8'hFF;
          vec_addr_d   = 8'd0;
          busy_d       = 1'b1;
          state_d      = S_LOAD;
        end
      end
      S_LOAD: begin
        core_key_d = bus.vec_key;
        if (mode_q != 2'd1) begin
          core_inp_d  = bus.vec_pt;
          enc_start_d = 1'b1;
          state_d     = S_E_GO;
        end else begin
          core_inp_d  = bus.vec_ct;
          dec_start_d = 1'b1;
          state_d     = S_D_GO;
        end
      end
      S_E_GO: begin
        cnt_d   = '0;
        state_d = S_E_WAIT;
      end
      S_E_WAIT: begin
        cnt_d = cnt_inc;
        if (bus.enc_ready) begin
          fail_hit = (bus.enc_out != bus.vec_ct);
          if (mode_q[1]) begin
            // Round-trip mode feeds the encrypt result straight back.
            core_inp_d  = mode_q[0] ? bus.enc_out : bus.vec_ct;
            dec_start_d = 1'b1;
            state_d     = S_D_GO;
          end else begin
            state_d = S_NEXT;
          end
        end else if (cnt_inc == CW'(TIMEOUT)) begin
          timeout_d = 1'b1;
          fail_hit  = 1'b1;
          state_d   = S_FIN;
        end
      end
      S_D_GO: begin
        cnt_d   = '0;
        state_d = S_D_WAIT;
      end
      S_D_WAIT: begin
        cnt_d = cnt_inc;
        if (bus.dec_ready) begin
          fail_hit = (bus.dec_out != bus.vec_pt);
          state_d  = S_NEXT;
        end else if (cnt_inc == CW'(TIMEOUT)) begin
          timeout_d = 1'b1;
          fail_hit  = 1'b1;
          state_d   = S_FIN;
        end
      end
      S_NEXT: begin
        if (vec_addr_q == 8'(NUM_VEC - 1)) begin
          state_d = S_FIN;
        end else begin
          vec_addr_d = vec_addr_q + 8'd1;
          state_d    = S_LOAD;
        end
      end
      S_FIN: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        pass_d  = (fail_cnt_q == 8'd0) && !timeout_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (fail_hit) begin
      if (fail_cnt_q == 8'd0) first_fail_d = vec_addr_q;
      if (fail_cnt_q != 8'hFF) fail_cnt_d = fail_cnt_q + 8'd1;
    end
  end

  assign bus.vec_addr   = vec_addr_q;
  assign bus.enc_start  = enc_start_q;
  assign bus.dec_start  = dec_start_q;
  assign bus.core_key   = core_key_q;
  assign bus.core_inp   = core_inp_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.pass       = pass_q;
  assign bus.fail_cnt   = fail_cnt_q;
  assign bus.first_fail = first_fail_q;
  assign bus.timeout    = timeout_q;

endmodule

// File: tb/tb_swan_kat_sequencer.sv
// Self-checking bench for swan_kat_sequencer with SWAN64K128 core
// models answering from the known-answer table.
module tb_swan_kat_sequencer;

  localparam int BS  = 64;
  localparam int KS  = 128;
  localparam int NV  = 3;
  localparam int TO  = 15;
  localparam int LAT = 3;

  typedef struct {
    logic [1:0] mode;
    bit         corrupt;
    bit         hang;
    bit         exp_pass;
    logic [7:0] exp_fc;
    logic [7:0] exp_ff;
    bit         exp_to;
  } vec_t;

  typedef struct {
    bit         pass;
    logic [7:0] fc;
    logic [7:0] ff;
    bit         to;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  swan_kat_sequencer_if #(.BLOCK_SIZE(BS), .KEY_SIZE(KS)) bus ();

  swan_kat_sequencer #(
    .BLOCK_SIZE(BS),
    .KEY_SIZE(KS),
    .NUM_VEC(NV),
    .TIMEOUT(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.master)
  );

  logic [KS-1:0] gk  [NV];
  logic [BS-1:0] gpt [NV];
  logic [BS-1:0] gct [NV];

  bit corrupt = 1'b0;
  bit hang    = 1'b0;

  int n_cmp = 0;
  int n_err = 0;
  exp_t sb[$];

  int done_cnt   = 0;
  int busy_cyc   = 0;
  int enc_pulses = 0;
  int dec_pulses = 0;
  int start_viol = 0;
  bit enc_prev   = 1'b0;
  bit dec_prev   = 1'b0;

  logic [BS-1:0] enc_seen, dec_seen;
  logic [BS-1:0] e_res, d_res;
  int e_cnt, d_cnt;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [BS-1:0] enc_f(logic [KS-1:0] k, logic [BS-1:0] x);
    for (int i = 0; i < NV; i++)
      if (k == gk[i] && x == gpt[i]) return gct[i];
    return x ^ 64'hA5A5_5A5A_0F0F_F0F0;
  endfunction

  function automatic logic [BS-1:0] dec_f(logic [KS-1:0] k, logic [BS-1:0] x);
    for (int i = 0; i < NV; i++)
      if (k == gk[i] && x == gct[i]) return gpt[i];
    return x ^ 64'h5A5A_A5A5_F0F0_0F0F;
  endfunction

  // Table ROM, with optional single-bit corruption of vector 1 ct.
  always_comb begin
    bus.vec_key = '0;
    bus.vec_pt  = '0;
    bus.vec_ct  = '0;
    if (bus.vec_addr < 8'(NV)) begin
      bus.vec_key = gk[bus.vec_addr[1:0]];
      bus.vec_pt  = gpt[bus.vec_addr[1:0]];
      bus.vec_ct  = gct[bus.vec_addr[1:0]]
                  ^ {63'd0, corrupt && (bus.vec_addr == 8'd1)};
    end
  end

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.enc_ready <= 1'b0;
      bus.enc_out   <= '0;
      e_cnt         <= 0;
    end else begin
      bus.enc_ready <= 1'b0;
      if (bus.enc_start) begin
        e_cnt    <= hang ? 0 : LAT - 1;
        e_res    <= enc_f(bus.core_key, bus.core_inp);
        enc_seen <= bus.core_inp;
      end else if (e_cnt > 0) begin
        e_cnt <= e_cnt - 1;
        if (e_cnt == 1) begin
          bus.enc_ready <= 1'b1;
          bus.enc_out   <= e_res;
        end
      end
    end
  end

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.dec_ready <= 1'b0;
      bus.dec_out   <= '0;
      d_cnt         <= 0;
    end else begin
      bus.dec_ready <= 1'b0;
      if (bus.dec_start) begin
        d_cnt    <= LAT - 1;
        d_res    <= dec_f(bus.core_key, bus.core_inp);
        dec_seen <= bus.core_inp;
      end else if (d_cnt > 0) begin
        d_cnt <= d_cnt - 1;
        if (d_cnt == 1) begin
          bus.dec_ready <= 1'b1;
          bus.dec_out   <= d_res;
        end
      end
    end
  end

  // Output monitor: start pulse shape and scoreboard on done.
  always @(negedge clk) begin
    exp_t e;
    if (bus.enc_start && bus.dec_start) start_viol++;
    if (bus.enc_start && enc_prev) start_viol++;
    if (bus.dec_start && dec_prev) start_viol++;
    enc_prev = bus.enc_start;
    dec_prev = bus.dec_start;
    if (bus.enc_start) enc_pulses++;
    if (bus.dec_start) dec_pulses++;
    if (bus.busy) busy_cyc++;
    if (bus.done) begin
      done_cnt++;
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_done: got done=1 expected none");
      end else begin
        e = sb.pop_front();
        chk("pass", 64'(bus.pass), 64'(e.pass));
        chk("fail_cnt", 64'(bus.fail_cnt), 64'(e.fc));
        chk("first_fail", 64'(bus.first_fail), 64'(e.ff));
        chk("timeout", 64'(bus.timeout), 64'(e.to));
        chk("busy_at_done", 64'(bus.busy), 64'd0);
      end
    end
  end

  task automatic wait_done();
    int i;
    i = 0;
    while (sb.size() != 0 && i < 2000) begin
      @(negedge clk);
      i++;
    end
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL done_wait: got no done in %0d cycles expected done", i);
      sb.delete();
    end
  endtask

  task automatic do_pass(vec_t v);
    exp_t e;
    corrupt  = v.corrupt;
    hang     = v.hang;
    bus.mode = v.mode;
    e.pass   = v.exp_pass;
    e.fc     = v.exp_fc;
    e.ff     = v.exp_ff;
    e.to     = v.exp_to;
    sb.push_back(e);
    bus.run = 1'b1;
    @(negedge clk);
    bus.run = 1'b0;
    wait_done();
    @(negedge clk);
  endtask

  vec_t tbl[9];

  initial begin
    int k, d0;
    vec_t ok2;

    gk[0]  = '0;
    gpt[0] = 64'h8877665544332211;
    gct[0] = 64'h94db436fab46b0ca;
    gk[1]  = {4{32'h78563412}};
    gpt[1] = 64'hefcdab9078563412;
    gct[1] = 64'hb933b6ea2bc9455d;
    gk[2]  = '1;
    gpt[2] = 64'hf0debc9a78563412;
    gct[2] = 64'h9728ec401eb2271e;

    tbl[0] = '{2'd2, 1'b0, 1'b0, 1'b1, 8'd0, 8'hFF, 1'b0};
    tbl[1] = '{2'd3, 1'b0, 1'b0, 1'b1, 8'd0, 8'hFF, 1'b0};
    tbl[2] = '{2'd0, 1'b0, 1'b0, 1'b1, 8'd0, 8'hFF, 1'b0};
    tbl[3] = '{2'd1, 1'b0, 1'b0, 1'b1, 8'd0, 8'hFF, 1'b0};
    tbl[4] = '{2'd2, 1'b1, 1'b0, 1'b0, 8'd2, 8'd1,  1'b0};
    tbl[5] = '{2'd0, 1'b1, 1'b0, 1'b0, 8'd1, 8'd1,  1'b0};
    tbl[6] = '{2'd1, 1'b1, 1'b0, 1'b0, 8'd1, 8'd1,  1'b0};
    tbl[7] = '{2'd3, 1'b1, 1'b0, 1'b0, 8'd1, 8'd1,  1'b0};
    tbl[8] = '{2'd0, 1'b0, 1'b1, 1'b0, 8'd1, 8'd0,  1'b1};
    ok2 = tbl[0];

    bus.run  = 1'b0;
    bus.mode = 2'd0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_pass", 64'(bus.pass), 64'd0);
    chk("rst_fail_cnt", 64'(bus.fail_cnt), 64'd0);
    chk("rst_first_fail", 64'(bus.first_fail), 64'hFF);
    chk("rst_timeout", 64'(bus.timeout), 64'd0);
    chk("rst_vec_addr", 64'(bus.vec_addr), 64'd0);
    chk("rst_starts", 64'({bus.enc_start, bus.dec_start}), 64'd0);
    chk("rst_core_inp", 64'(bus.core_inp), 64'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    foreach (tbl[i]) do_pass(tbl[i]);

    // Round trip: last vector's cores see pt then the encrypt result.
    tbl[1].mode = 2'd3;
    do_pass(tbl[1]);
    chk("rt_enc_inp", enc_seen, gpt[2]);
    chk("rt_dec_inp", dec_seen, gct[2]);

    // Cycle-accurate pass length and start pulse counts.
    busy_cyc = 0;
    do_pass(tbl[2]);
    chk("busy_cycles_mode0", 64'(busy_cyc), 64'(NV * (LAT + 3) + 1));
    busy_cyc   = 0;
    enc_pulses = 0;
    dec_pulses = 0;
    do_pass(ok2);
    chk("busy_cycles_mode2", 64'(busy_cyc), 64'(NV * (2 * LAT + 4) + 1));
    chk("enc_pulses", 64'(enc_pulses), 64'(NV));
    chk("dec_pulses", 64'(dec_pulses), 64'(NV));

    // Timeout latency measured from the enc_start cycle.
    hang     = 1'b1;
    corrupt  = 1'b0;
    bus.mode = 2'd0;
    sb.push_back('{1'b0, 8'd1, 8'd0, 1'b1});
    bus.run = 1'b1;
    @(negedge clk);
    bus.run = 1'b0;
    k = 0;
    while (!bus.enc_start && k < 100) begin
      @(negedge clk);
      k++;
    end
    k = 0;
    while (!bus.timeout && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("timeout_latency", 64'(k), 64'd16);
    wait_done();
    hang = 1'b0;
    @(negedge clk);

    // Reset during E_WAIT of vector 1 aborts without done.
    bus.mode = 2'd2;
    corrupt  = 1'b1;
    bus.run  = 1'b1;
    @(negedge clk);
    bus.run = 1'b0;
    k = 0;
    while (!(bus.enc_start && bus.vec_addr == 8'd1) && k < 200) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    d0  = done_cnt;
    rst = 1'b0;
    #1;
    chk("midrst_busy", 64'(bus.busy), 64'd0);
    chk("midrst_first_fail", 64'(bus.first_fail), 64'hFF);
    chk("midrst_fail_cnt", 64'(bus.fail_cnt), 64'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (10) @(negedge clk);
    chk("midrst_no_done", 64'(done_cnt), 64'(d0));
    do_pass(ok2);

    // Run held high across a pass starts exactly one pass.
    d0      = done_cnt;
    corrupt = 1'b0;
    bus.mode = 2'd2;
    sb.push_back('{1'b1, 8'd0, 8'hFF, 1'b0});
    bus.run = 1'b1;
    wait_done();
    repeat (60) @(negedge clk);
    chk("held_run_passes", 64'(done_cnt), 64'(d0 + 1));
    chk("held_run_idle", 64'(bus.busy), 64'd0);
    bus.run = 1'b0;
    repeat (2) @(negedge clk);

    chk("start_shape", 64'(start_viol), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/swan_kat_sequencer.md
Name: swan_kat_sequencer

Overview:
Synthesizable known-answer-test (KAT) sequencer for SWAN block-cipher cores. It walks a table of (key, plaintext, ciphertext) vectors and drives an external SWAN encrypt core and decrypt core with the start/ready handshake. It compares each result and reports the pass/fail status. It sits beside SWAN64K128_ENC/DEC, or any BLOCK_SIZE/KEY_SIZE variant, as an on-chip self-test, replacing per-vector simulation benches.

Parameters:
BLOCK_SIZE, 64, cipher block width in bits
KEY_SIZE, 128, key width in bits
NUM_VEC, 3, number of vectors in the external table (1..255)
TIMEOUT, 1023, maximum cycles to wait for core ready before declaring a fault

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  asynchronous reset, active-low
run  in  1  rising-edge-detected request to start a test pass
mode  in  2  0 = encrypt only, 1 = decrypt only, 2 = both, 3 = round-trip (decrypt the core's own encrypt output)
vec_addr  out  8  table index being requested
vec_key  in  KEY_SIZE  key at vec_addr (combinational lookup)
vec_pt  in  BLOCK_SIZE  plaintext at vec_addr
vec_ct  in  BLOCK_SIZE  ciphertext at vec_addr
enc_start  out  1  start pulse to encrypt core
dec_start  out  1  start pulse to decrypt core
core_key  out  KEY_SIZE  registered key to both cores
core_inp  out  BLOCK_SIZE  registered input block to both cores
enc_out  in  BLOCK_SIZE  encrypt core result
enc_ready  in  1  encrypt result valid
dec_out  in  BLOCK_SIZE  decrypt core result
dec_ready  in  1  decrypt result valid
busy  out  1  pass in progress
done  out  1  one-cycle pulse at end of pass
pass  out  1  sticky: last pass had zero failures and no timeout
fail_cnt  out  8  mismatching operations in last pass (saturates at 255)
first_fail  out  8  vec_addr of first failure; 8'hFF if none
timeout  out  1  sticky: a core failed to raise ready within TIMEOUT cycles

Behaviour:
- Reset (rst=0, async): state IDLE. All outputs are 0, except first_fail=8'hFF. The run edge detector is cleared.
- States: IDLE, LOAD, E_GO, E_WAIT, D_GO, D_WAIT, NEXT, FIN.
- IDLE: on a run rising edge (run=1, run_q=0), latch mode. Clear fail_cnt, pass, timeout; set first_fail=FF, vec_addr=0, busy=1; go to LOAD. The run edge is ignored while busy.
- LOAD: register core_key<=vec_key. Go to E_GO if mode!=1, else D_GO.
- E_GO: core_inp<=vec_pt; enc_start=1 for exactly this cycle; the timeout counter resets to 0; go to E_WAIT.
- E_WAIT: the counter increments each cycle.
  - On enc_ready=1: compare enc_out with vec_ct and capture enc_out into a round-trip register.
  - Then go to D_GO if mode is 2 or 3, else NEXT.
  - If the counter reaches TIMEOUT first: set timeout, count one failure, go to FIN (pass aborted).
- D_GO: core_inp<=vec_ct, or the round-trip register in mode 3; dec_start=1 for one cycle; counter reset; go to D_WAIT.
- D_WAIT: same as E_WAIT using dec_ready/dec_out, compared against vec_pt. Then go to NEXT.
- Failure accounting: each mismatching compare increments fail_cnt (saturating). The first mismatch loads first_fail=vec_addr. In mode 2 one vector can contribute 2 failures.
- NEXT: if vec_addr==NUM_VEC-1 go to FIN, else vec_addr+1 and go to LOAD.
- FIN: busy=0; done=1 for one cycle; pass=(fail_cnt==0 && !timeout); go to IDLE. vec_addr holds its last value.
- ready arriving the same cycle as start, or while not in a WAIT state, is ignored.
- Latency per vector, with core latency L (cycles from start to ready): 2+L+1 (single direction), 2*(L+1)+2 (modes 2/3).
- Reset mid-pass: immediate return to IDLE with reset output values; no done pulse.

Test Plan:
- BLOCK_SIZE=64, KEY_SIZE=128. Table: (0, 8877665544332211, 94db436fab46b0ca), (78563412×4, efcdab9078563412, b933b6ea2bc9455d), (FF…FF, f0debc9a78563412, 9728ec401eb2271e). Run mode 2 with real SWAN64K128 cores -> done after 3 vectors, pass=1, fail_cnt=0, first_fail=FF.
- Same setup, mode 3 -> enc core sees f0debc9a78563412 then dec core sees 9728ec401eb2271e on vector 2; pass=1.
- Corrupt vector 1 ct to b933b6ea2bc9455c, mode 2 -> fail_cnt=2, first_fail=1, pass=0. Mode 0 on the same table -> fail_cnt=1.
- Encrypt-core model never asserts ready, TIMEOUT=15 -> timeout=1 at 16 cycles after enc_start; done pulses; pass=0; fail_cnt=1.
- Assert rst low during E_WAIT of vector 1 -> busy=0, first_fail=FF, no done pulse. A new run then completes normally.
- Hold run high across a full pass -> exactly one pass executes. Also check: enc_start and dec_start are each exactly one cycle wide and never high together.
